display_mode_ctrl: RTL and testbench
====================================

Name: display_mode_ctrl

Overview:
- Mode sequencer for the time display.
- Debounces three front-panel buttons and runs the CLOCK / TIMER / STOPWATCH / clock-set state machine.
- Drives the display mux select, the edit-field blink, and the increment strobes into the clock counter.
- Gives priority to timer-expiry alerts, which force the TIMER view.

Parameters:
- DEBOUNCE_TICKS, 20: consecutive ticks a raw button level must hold before it is accepted.
- BLINK_TICKS, 250: ticks per blink half-period while editing.
- IDLE_TICKS, 10000: ticks without an accepted press before auto-return to CLOCK (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  1 kHz single-cycle strobe; all timing counts these
- btn_mode  in  1  raw mode button, already synchronised, active-high
- btn_set  in  1  raw set button
- btn_inc  in  1  raw increment button
- tmr_alert  in  1  single-cycle timer-expired pulse
- sel  out  2  display select: 01 clock, 10 timer, 11 stopwatch; never 00
- edit_field  out  2  00 none, 01 hours, 10 minutes, 11 seconds
- blink  out  1  blank-the-edited-field phase
- clk_hold  out  1  high in any SET state; freezes the clock counter
- inc_hours  out  1  one-cycle increment strobe
- inc_minutes  out  1  one-cycle increment strobe
- inc_seconds  out  1  one-cycle increment strobe

Behaviour:
- Reset values: state CLOCK, sel=01, edit_field=00, blink=0, clk_hold=0, all inc_* pulses=0. Debouncers clear to released; all counters clear to 0.
- Debounce, per button:
  - Counter advances on tick while the raw level differs from the accepted level; it clears when the levels match.
  - On reaching DEBOUNCE_TICKS, the accepted level flips.
  - An accepted 0->1 transition yields exactly one press pulse, registered, one clk after the flip.
  - Releases generate nothing.
- States: CLOCK, TIMER, STOPWATCH, SET_H, SET_M, SET_S.
- Transitions, evaluated on the press/alert cycle and taking effect on the next clk:
  - mode press: CLOCK->TIMER->STOPWATCH->CLOCK. In any SET_x it aborts to CLOCK; no further increments are issued.
  - set press: CLOCK->SET_H->SET_M->SET_S->CLOCK. Ignored in TIMER and STOPWATCH.
  - inc press in SET_H/M/S: the matching inc_* is high for exactly one clk, one cycle after the press pulse. Ignored in every other state.
  - tmr_alert in CLOCK or STOPWATCH: go to TIMER. In TIMER: no change.
  - tmr_alert in SET_x: sets alert_pending. On leaving the SET states, the next state is TIMER instead of CLOCK, and pending clears.
- Simultaneous events:
  - alert > mode > set > inc.
  - In SET_x, mode+inc in the same cycle: abort, no inc pulse.
  - In SET_x, set+inc in the same cycle: advance field, no inc pulse.
- Outputs are registered from state: sel=01 in all SET states.
- edit_field follows SET_x; 00 elsewhere.
- Blink:
  - On entering any SET state, blink=1 and the blink counter clears.
  - blink toggles every BLINK_TICKS ticks.
  - The counter restarts on each field change and on each inc press, leaving the field visible (blink=1).
  - blink forced 0 outside SET states.
- tick and press coincident: both are handled; counters use the post-transition state.
- reset mid-edit: returns to CLOCK immediately; alert_pending cleared.

Optional Feature:
- Macro: DISPLAY_MODE_AUTO_RETURN_EN.
- Defined:
  - Idle counter increments on tick in TIMER, STOPWATCH and SET_x, and clears on any accepted press or state change.
  - At IDLE_TICKS it returns to CLOCK; from SET_x it honours alert_pending by going to TIMER.
- Undefined: no idle counter; states persist indefinitely.

Decomposition:
- Package display_pkg holds:
  - mode_e enum (6 states)
  - SEL_CLOCK=2'b01, SEL_TIMER=2'b10, SEL_SW=2'b11
  - FIELD_NONE/HOURS/MINUTES/SECONDS
- Sub-module btn_debounce (parameter DEBOUNCE_TICKS; ports clk, reset, tick, raw, press), instantiated three times.

Test Plan (bench params DEBOUNCE_TICKS=4, BLINK_TICKS=3, IDLE_TICKS=20):
- Reset, then btn_mode held 4 ticks, released, repeated 3 times -> sel 01->10->11->01; a 3-tick glitch on btn_mode -> no change.
- btn_set press from CLOCK, then 2 inc presses -> edit_field=01, clk_hold=1, inc_hours pulses exactly twice, one clk each. Then 3 more set presses -> edit_field 10, 11, 00; clk_hold=0.
- In SET_H with no presses -> blink 1,0,1 toggling every 3 ticks; an inc press restarts with blink=1.
- tmr_alert pulse in STOPWATCH -> sel=10 next clk. Alert during SET_M, then mode press -> sel=10, edit_field=00.
- Same-cycle accepted mode and set presses in CLOCK -> TIMER only. reset asserted in SET_S -> sel=01, clk_hold=0, blink=0 after one clk.
- With DISPLAY_MODE_AUTO_RETURN_EN: 20 idle ticks in TIMER -> sel=01. Without the macro: after 100 ticks, sel stays 10.

Source files
------------

// File: rtl/display_mode_ctrl_pkg.sv
// Shared types and constants for the display mode sequencer: the mode
// enumeration, display-select and edit-field codes, and per-mode decode helpers.
package display_pkg;

  typedef enum logic [2:0] {
    MODE_CLOCK = 3'd0,
    MODE_TIMER = 3'd1,
    MODE_SW    = 3'd2,
    MODE_SET_H = 3'd3,
    MODE_SET_M = 3'd4,
    MODE_SET_S = 3'd5
  } mode_e;

  localparam logic [1:0] SEL_CLOCK = 2'b01;
  localparam logic [1:0] SEL_TIMER = 2'b10;
  localparam logic [1:0] SEL_SW    = 2'b11;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;
  localparam logic [1:0] FIELD_SECONDS = 2'b11;

  function automatic logic is_set(mode_e m);
    return (m == MODE_SET_H) || (m == MODE_SET_M) || (m == MODE_SET_S);
  endfunction

  // The SET states keep the clock view so the field being edited is visible.
  function automatic logic [1:0] sel_of(mode_e m);
    case (m)
      MODE_TIMER: return SEL_TIMER;
      MODE_SW:    return SEL_SW;
      default:    return SEL_CLOCK;
    endcase
  endfunction

  function automatic logic [1:0] field_of(mode_e m);
    case (m)
      MODE_SET_H: return FIELD_HOURS;
      MODE_SET_M: return FIELD_MINUTES;
      MODE_SET_S: return FIELD_SECONDS;
      default:    return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/display_mode_ctrl_if.sv
// Front-panel / display bundle of the mode sequencer. The slave side is the
// sequencer itself; the master side is whatever drives the buttons and tick.
interface display_mode_ctrl_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_set;
  logic       btn_inc;
  logic       tmr_alert;
  logic [1:0] sel;
  logic [1:0] edit_field;
  logic       blink;
  logic       clk_hold;
  logic       inc_hours;
  logic       inc_minutes;
  logic       inc_seconds;

  modport master (
    output tick, btn_mode, btn_set, btn_inc, tmr_alert,
    input  sel, edit_field, blink, clk_hold, inc_hours, inc_minutes, inc_seconds
  );

  modport slave (
    input  tick, btn_mode, btn_set, btn_inc, tmr_alert,
    output sel, edit_field, blink, clk_hold, inc_hours, inc_minutes, inc_seconds
  );
endinterface

// File: rtl/display_mode_ctrl_btn_debounce.sv
// Tick-based button debouncer: the accepted level follows the raw level after it
// has differed for DEBOUNCE_TICKS consecutive ticks; each accepted press gives one pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_TICKS = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          rose_q, rose_d;
  logic          press_q;

  // Count ticks of disagreement; a full run flips the accepted level.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    rose_d = 1'b0;
    if (raw == acc_q) begin
      cnt_d = CW'(0);
    end else if (tick) begin
      if (cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
        acc_d  = raw;
        cnt_d  = CW'(0);
        rose_d = raw;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Debounce state and the press pulse one clock behind the accepted rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= CW'(0);
      acc_q   <= 1'b0;
      rose_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rose_q  <= rose_d;
      press_q <= rose_q;
    end
  end

  assign press = press_q;
endmodule

// File: rtl/display_mode_ctrl.sv
// Display mode sequencer: CLOCK/TIMER/STOPWATCH views plus the clock-set states.
// Optional idle auto-return to CLOCK is enabled by DISPLAY_MODE_AUTO_RETURN_EN.
module display_mode_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 20,
  parameter int unsigned BLINK_TICKS    = 250
`ifdef DISPLAY_MODE_AUTO_RETURN_EN
  , parameter int unsigned IDLE_TICKS   = 10000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  display_mode_ctrl_if.slave bus
);
  localparam int BW = $clog2(BLINK_TICKS + 1);

  mode_e         state_q, state_d;
  logic          pend_q, pend_d;
  logic [1:0]    sel_q, field_q;
  logic          hold_q, blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    inc_q;
  logic          mode_press_s, set_press_s, inc_press_s;
  logic          inc_ok_s, in_set_s, idle_to_s;
  mode_e         exit_s;

  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_mode (
    .clk(clk), .reset(reset), .tick(bus.tick), .raw(bus.btn_mode), .press(mode_press_s));
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_set (
    .clk(clk), .reset(reset), .tick(bus.tick), .raw(bus.btn_set), .press(set_press_s));
  btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_inc (
    .clk(clk), .reset(reset), .tick(bus.tick), .raw(bus.btn_inc), .press(inc_press_s));

  assign in_set_s = is_set(state_q);
  // An alert that arrived while editing redirects the exit to the timer view.
  assign exit_s   = pend_q ? MODE_TIMER : MODE_CLOCK;

  // Next mode: alert, then mode, then set, then inc, then idle timeout.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    inc_ok_s = 1'b0;
    if (bus.tmr_alert) begin
      if (in_set_s) begin
        pend_d = 1'b1;
      end else begin
        state_d = MODE_TIMER;
      end
    end else if (mode_press_s) begin
      case (state_q)
        MODE_CLOCK: state_d = MODE_TIMER;
        MODE_TIMER: state_d = MODE_SW;
        MODE_SW:    state_d = MODE_CLOCK;
        default: begin
          state_d = exit_s;
          pend_d  = 1'b0;
        end
      endcase
    end else if (set_press_s) begin
      case (state_q)
        MODE_CLOCK: state_d = MODE_SET_H;
        MODE_SET_H: state_d = MODE_SET_M;
        MODE_SET_M: state_d = MODE_SET_S;
        MODE_SET_S: begin
          state_d = exit_s;
          pend_d  = 1'b0;
        end
        MODE_TIMER, MODE_SW: state_d = state_q;
        default:    state_d = MODE_CLOCK;
      endcase
    end else if (inc_press_s) begin
      inc_ok_s = in_set_s;
    end else if (idle_to_s) begin
      if (in_set_s) begin
        state_d = exit_s;
        pend_d  = 1'b0;
      end else begin
        state_d = MODE_CLOCK;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Blink phase runs only while editing and restarts visible on any field change or increment.
  always_comb begin
    blink_d = 1'b0;
    bcnt_d  = BW'(0);
    if (is_set(state_d)) begin
      if ((state_d != state_q) || inc_ok_s) begin
        blink_d = 1'b1;
        bcnt_d  = BW'(0);
      end else if (bus.tick) begin
        if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
          blink_d = ~blink_q;
          bcnt_d  = BW'(0);
        end else begin
          blink_d = blink_q;
          bcnt_d  = bcnt_q + BW'(1);
        end
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
      end
    end else begin
      blink_d = 1'b0;
      bcnt_d  = BW'(0);
    end
  end

  // Mode register and display outputs, decoded from the next mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MODE_CLOCK;
      pend_q  <= 1'b0;
      sel_q   <= SEL_CLOCK;
      field_q <= FIELD_NONE;
      hold_q  <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= BW'(0);
      inc_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sel_q   <= sel_of(state_d);
      field_q <= field_of(state_d);
      hold_q  <= is_set(state_d);
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
      inc_q   <= {inc_ok_s && (state_q == MODE_SET_H),
                  inc_ok_s && (state_q == MODE_SET_M),
                  inc_ok_s && (state_q == MODE_SET_S)};
    end
  end

`ifdef DISPLAY_MODE_AUTO_RETURN_EN
  localparam int IW = $clog2(IDLE_TICKS + 1);

  logic [IW-1:0] idle_q, idle_d;

  assign idle_to_s = (idle_q >= IW'(IDLE_TICKS)) && (state_q != MODE_CLOCK);

  // Idle ticks outside CLOCK, saturating; any press or mode change clears it.
  always_comb begin
    idle_d = idle_q;
    if (mode_press_s || set_press_s || inc_press_s || (state_d != state_q)) begin
      idle_d = IW'(0);
    end else if (bus.tick && (state_q != MODE_CLOCK) && (idle_q < IW'(IDLE_TICKS))) begin
      idle_d = idle_q + IW'(1);
    end else begin
      idle_d = idle_q;
    end
  end

  // Idle counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= IW'(0);
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign idle_to_s = 1'b0;
`endif

  assign bus.sel         = sel_q;
  assign bus.edit_field  = field_q;
  assign bus.blink       = blink_q;
  assign bus.clk_hold    = hold_q;
  assign bus.inc_hours   = inc_q[2];
  assign bus.inc_minutes = inc_q[1];
  assign bus.inc_seconds = inc_q[0];
endmodule

// File: tb/tb_display_mode_ctrl.sv
// Self-checking bench for display_mode_ctrl: a per-cycle reference model built on
// view/field arithmetic, a table of button operations, directed corner sequences and random traffic.
module tb_display_mode_ctrl;
  localparam int DEB = 4;
  localparam int BLK = 3;
  localparam int IDL = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  display_mode_ctrl_if dif ();

`ifdef DISPLAY_MODE_AUTO_RETURN_EN
  display_mode_ctrl #(.DEBOUNCE_TICKS(DEB), .BLINK_TICKS(BLK), .IDLE_TICKS(IDL)) dut (
    .clk(clk), .reset(rst), .bus(dif));
`else
  display_mode_ctrl #(.DEBOUNCE_TICKS(DEB), .BLINK_TICKS(BLK)) dut (
    .clk(clk), .reset(rst), .bus(dif));
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int inc_seen = 0;

  // Reference model: view 0 clock / 1 timer / 2 stopwatch; field 0 none / 1 h / 2 m / 3 s.
  int m_view, m_field, m_pend, m_bcnt, m_idle;
  bit m_blink;
  bit [2:0] m_inc;
  int db_cnt[3];
  bit db_acc[3];
  bit db_rise[3];
  bit m_press[3];

  typedef struct {
    int btn;          // 0 mode, 1 set, 2 inc, 3 alert pulse
    logic [1:0] sel;
    logic [1:0] field;
    logic hold;
    int incs;
  } vec_t;
  vec_t tab[19];

  function automatic vec_t mkv(int b, logic [1:0] s, logic [1:0] f, logic h, int n);
    vec_t v;
    v.btn = b; v.sel = s; v.field = f; v.hold = h; v.incs = n;
    return v;
  endfunction

  function automatic bit raw_of(int b);
    if (b == 0) return dif.btn_mode;
    else if (b == 1) return dif.btn_set;
    else return dif.btn_inc;
  endfunction

  task automatic set_raw(int b, bit v);
    if (b == 0) dif.btn_mode = v;
    else if (b == 1) dif.btn_set = v;
    else dif.btn_inc = v;
  endtask

  task automatic model_reset();
    m_view = 0; m_field = 0; m_pend = 0; m_bcnt = 0; m_idle = 0;
    m_blink = 1'b0; m_inc = 3'b000;
    for (int b = 0; b < 3; b++) begin
      db_cnt[b] = 0; db_acc[b] = 1'b0; db_rise[b] = 1'b0; m_press[b] = 1'b0;
    end
  endtask

  task automatic leave_set();
    m_field = 0;
    m_view  = (m_pend != 0) ? 1 : 0;
    m_pend  = 0;
  endtask

  task automatic model_step();
    int ov, of;
    bit inc_ok, changed, any_press;
    bit r;
    if (rst) begin
      model_reset();
      return;
    end
    ov = m_view; of = m_field; inc_ok = 1'b0;
    any_press = m_press[0] | m_press[1] | m_press[2];
    if (dif.tmr_alert) begin
      if (of != 0) m_pend = 1; else m_view = 1;
    end else if (m_press[0]) begin
      if (of != 0) leave_set(); else m_view = (ov + 1) % 3;
    end else if (m_press[1]) begin
      if (of != 0) begin
        m_field = (of + 1) % 4;
        if (m_field == 0) leave_set();
      end else if (ov == 0) begin
        m_field = 1;
      end
    end else if (m_press[2]) begin
      inc_ok = (of != 0);
    end
`ifdef DISPLAY_MODE_AUTO_RETURN_EN
    else if (m_idle >= IDL && !(ov == 0 && of == 0)) begin
      if (of != 0) leave_set(); else m_view = 0;
    end
`endif
    changed = (m_view != ov) || (m_field != of);
    m_inc = {inc_ok && of == 1, inc_ok && of == 2, inc_ok && of == 3};
    if (m_field != 0) begin
      if (changed || inc_ok) begin
        m_blink = 1'b1; m_bcnt = 0;
      end else if (dif.tick) begin
        m_bcnt++;
        if (m_bcnt == BLK) begin m_blink = !m_blink; m_bcnt = 0; end
      end
    end else begin
      m_blink = 1'b0; m_bcnt = 0;
    end
`ifdef DISPLAY_MODE_AUTO_RETURN_EN
    if (any_press || changed) m_idle = 0;
    else if (dif.tick && !(ov == 0 && of == 0) && m_idle < IDL) m_idle++;
`endif
    for (int b = 0; b < 3; b++) begin
      m_press[b] = db_rise[b];
      db_rise[b] = 1'b0;
      r = raw_of(b);
      if (r == db_acc[b]) begin
        db_cnt[b] = 0;
      end else if (dif.tick) begin
        db_cnt[b]++;
        if (db_cnt[b] == DEB) begin
          db_acc[b] = r; db_cnt[b] = 0; db_rise[b] = r;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model();
    int s;
    logic [9:0] act, exp;
    s = (m_field != 0) ? 1 : m_view + 1;
    act = {dif.sel, dif.edit_field, dif.blink, dif.clk_hold,
           dif.inc_hours, dif.inc_minutes, dif.inc_seconds};
    exp = {s[1:0], m_field[1:0], m_blink, (m_field != 0), m_inc};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got %b expected %b (sel,field,blink,hold,inc_hms)", cyc, act, exp);
    end
  endtask

  // One clock: model follows the same edge, outputs compared 1 ns later.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_model();
    inc_seen += int'(dif.inc_hours) + int'(dif.inc_minutes) + int'(dif.inc_seconds);
    cyc++;
    dif.tick = ((cyc % 2) == 0);
  endtask

  task automatic press(int b);
    set_raw(b, 1'b1);
    repeat (12) step();
    set_raw(b, 1'b0);
    repeat (12) step();
  endtask

  task automatic do_op(int b);
    inc_seen = 0;
    if (b == 3) begin
      dif.tmr_alert = 1'b1;
      step();
      dif.tmr_alert = 1'b0;
      repeat (4) step();
    end else begin
      press(b);
    end
  endtask

  initial begin
    int found, tcount;
    bit lt;
    int b;

    tab[0]  = mkv(0, 2'b10, 2'b00, 1'b0, 0);
    tab[1]  = mkv(0, 2'b11, 2'b00, 1'b0, 0);
    tab[2]  = mkv(0, 2'b01, 2'b00, 1'b0, 0);
    tab[3]  = mkv(1, 2'b01, 2'b01, 1'b1, 0);
    tab[4]  = mkv(2, 2'b01, 2'b01, 1'b1, 1);
    tab[5]  = mkv(2, 2'b01, 2'b01, 1'b1, 1);
    tab[6]  = mkv(1, 2'b01, 2'b10, 1'b1, 0);
    tab[7]  = mkv(2, 2'b01, 2'b10, 1'b1, 1);
    tab[8]  = mkv(1, 2'b01, 2'b11, 1'b1, 0);
    tab[9]  = mkv(1, 2'b01, 2'b00, 1'b0, 0);
    tab[10] = mkv(2, 2'b01, 2'b00, 1'b0, 0);
    tab[11] = mkv(0, 2'b10, 2'b00, 1'b0, 0);
    tab[12] = mkv(1, 2'b10, 2'b00, 1'b0, 0);
    tab[13] = mkv(2, 2'b10, 2'b00, 1'b0, 0);
    tab[14] = mkv(0, 2'b11, 2'b00, 1'b0, 0);
    tab[15] = mkv(3, 2'b10, 2'b00, 1'b0, 0);
    tab[16] = mkv(3, 2'b10, 2'b00, 1'b0, 0);
    tab[17] = mkv(0, 2'b11, 2'b00, 1'b0, 0);
    tab[18] = mkv(0, 2'b01, 2'b00, 1'b0, 0);

    rst = 1'b1;
    dif.tick = 1'b0; dif.btn_mode = 1'b0; dif.btn_set = 1'b0;
    dif.btn_inc = 1'b0; dif.tmr_alert = 1'b0;
    model_reset();
    step(); step();
    chk("reset_sel", dif.sel, 2'b01);
    chk("reset_field", dif.edit_field, 2'b00);
    chk("reset_blink", dif.blink, 1'b0);
    chk("reset_hold", dif.clk_hold, 1'b0);
    chk("reset_inc", {dif.inc_hours, dif.inc_minutes, dif.inc_seconds}, 3'b000);
    rst = 1'b0;
    step();

    // 3-tick glitch is shorter than the debounce window
    dif.btn_mode = 1'b1;
    repeat (6) step();
    dif.btn_mode = 1'b0;
    repeat (12) step();
    chk("glitch_sel", dif.sel, 2'b01);

    for (int i = 0; i < 19; i++) begin
      do_op(tab[i].btn);
      chk($sformatf("vec%0d_sel", i), dif.sel, tab[i].sel);
      chk($sformatf("vec%0d_field", i), dif.edit_field, tab[i].field);
      chk($sformatf("vec%0d_hold", i), dif.clk_hold, tab[i].hold);
      chk($sformatf("vec%0d_incs", i), inc_seen, tab[i].incs);
    end

    // Blink phase in SET_H, restarted by a held inc press
    press(1);
    set_raw(2, 1'b1);
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      if (dif.inc_hours) found = 1;
    end
    chk("blink_inc_seen", found, 1);
    chk("blink_restart", dif.blink, 1'b1);
    tcount = 0;
    for (int i = 0; i < 20 && tcount < 6; i++) begin
      lt = dif.tick;
      step();
      if (lt) begin
        tcount++;
        if (tcount == 2) chk("blink_tick2", dif.blink, 1'b1);
        else if (tcount == 3) chk("blink_tick3", dif.blink, 1'b0);
        else if (tcount == 5) chk("blink_tick5", dif.blink, 1'b0);
        else if (tcount == 6) chk("blink_tick6", dif.blink, 1'b1);
      end
    end
    chk("blink_ticks_seen", tcount, 6);
    set_raw(2, 1'b0);
    repeat (10) step();
    press(1); press(1); press(1);
    chk("blink_exit_field", dif.edit_field, 2'b00);
    chk("blink_exit_hold", dif.clk_hold, 1'b0);

    // Alert while editing minutes, then abort lands in TIMER
    press(1); press(1);
    do_op(3);
    chk("alert_set_sel", dif.sel, 2'b01);
    chk("alert_set_field", dif.edit_field, 2'b10);
    press(0);
    chk("alert_abort_sel", dif.sel, 2'b10);
    chk("alert_abort_field", dif.edit_field, 2'b00);
    chk("alert_abort_hold", dif.clk_hold, 1'b0);
    press(0); press(0);
    chk("back_to_clock", dif.sel, 2'b01);

    // Mode and set accepted on the same cycle: mode wins
    dif.btn_mode = 1'b1; dif.btn_set = 1'b1;
    repeat (12) step();
    dif.btn_mode = 1'b0; dif.btn_set = 1'b0;
    repeat (12) step();
    chk("both_sel", dif.sel, 2'b10);
    chk("both_field", dif.edit_field, 2'b00);
    press(0); press(0);

    // Reset in SET_S with an alert pending
    press(1);
    do_op(3);
    press(1); press(1);
    chk("sets_field", dif.edit_field, 2'b11);
    rst = 1'b1;
    step();
    chk("rst_mid_sel", dif.sel, 2'b01);
    chk("rst_mid_hold", dif.clk_hold, 1'b0);
    chk("rst_mid_blink", dif.blink, 1'b0);
    chk("rst_mid_field", dif.edit_field, 2'b00);
    rst = 1'b0;
    step();
    press(1); press(1); press(1); press(1);
    chk("pend_cleared_sel", dif.sel, 2'b01);

    // Idle in TIMER
    press(0);
    repeat (IDL * 10) step();
`ifdef DISPLAY_MODE_AUTO_RETURN_EN
    chk("idle_sel", dif.sel, 2'b01);
`else
    chk("idle_sel", dif.sel, 2'b10);
    press(0); press(0);
`endif

    // Random button and alert traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 2);
        set_raw(b, !raw_of(b));
      end
      dif.tmr_alert = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      step();
    end
    dif.tmr_alert = 1'b0; rst = 1'b0;
    dif.btn_mode = 1'b0; dif.btn_set = 1'b0; dif.btn_inc = 1'b0;
    repeat (20) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
